// File: rtl/fifo_pkg.sv
// Shared defaults and FSM encoding for the FIFO read-side (drain) controller.
package fifo_pkg;

    localparam int DATA_BITS  = 10;
    localparam int ADDR_BITS  = 3;
    localparam int DEPTH      = 1 << ADDR_BITS;
    localparam int SKID_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        ERR   = 2'd3
    } drain_state_e;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Downstream valid/ready word stream leaving the drain controller.
interface fifo_drain_ctrl_if #(
    parameter int DATA_BITS = fifo_pkg::DATA_BITS
);

    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/skid_buf.sv
// Small circular skid buffer: push at the tail, pop from the head, wrapping pointers.
module skid_buf #(
    parameter int DATA_BITS  = 10,
    parameter int SKID_DEPTH = 4,
    localparam int PTR_BITS  = $clog2(SKID_DEPTH),
    localparam int CNT_BITS  = PTR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head_data,
    output logic [CNT_BITS-1:0]  count
);

    logic [DATA_BITS-1:0] mem [SKID_DEPTH];
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS-1:0]  wr_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop    = pop & (count != '0);
    assign do_push   = push & ((count != CNT_BITS'(SKID_DEPTH)) | do_pop);
    assign head_data = mem[rd_ptr];

    // NOTE: storage carries no reset; an empty buffer is defined by count, and
    // the consumer masks head_data whenever count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO controller: issues reads, buffers returning words, mirrors
// occupancy, throttles the writer with hysteresis and latches protocol errors.
module fifo_drain_ctrl #(
    parameter int DATA_BITS  = fifo_pkg::DATA_BITS,
    parameter int ADDR_BITS  = fifo_pkg::ADDR_BITS,
    parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] high_limit,
    input  logic [ADDR_BITS-1:0] low_limit,
    input  logic                 fifo_write,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    input  logic                 fifo_error,
    input  logic [DATA_BITS-1:0] fifo_data_out,
    output logic                 fifo_read,
    output logic                 pause_write,
    output logic [ADDR_BITS:0]   occupancy,
    output logic                 error_out,
    fifo_drain_ctrl_if.master    out_if
);

    import fifo_pkg::*;

    localparam int CNT_BITS   = $clog2(SKID_DEPTH) + 1;
    localparam int OCC_BITS   = ADDR_BITS + 1;
    localparam int FIFO_DEPTH = 1 << ADDR_BITS;

    drain_state_e         state;
    drain_state_e         state_next;
    logic                 rd_pending;
    logic                 read_next;
    logic [OCC_BITS-1:0]  occ_next;
    logic [CNT_BITS-1:0]  buf_cnt;
    logic [CNT_BITS:0]    used;
    logic [DATA_BITS-1:0] head_data;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 has_credit;
    logic                 avail;
    logic                 err_now;
    logic                 pop;

    assign wr_acc = fifo_write & ~fifo_full;
    assign rd_acc = fifo_read & ~fifo_empty;

    // Reads already issued or returning still need a slot, so they count against credit.
    assign used       = {1'b0, buf_cnt} + (CNT_BITS+1)'(fifo_read) + (CNT_BITS+1)'(rd_pending);
    assign has_credit = used < (CNT_BITS+1)'(SKID_DEPTH);
    assign avail      = occupancy > OCC_BITS'(fifo_read);

    assign err_now = fifo_error
                   | ((occupancy == '0) & ~fifo_empty)
                   | ((occupancy == OCC_BITS'(FIFO_DEPTH)) & ~fifo_full);

    assign out_if.out_valid = (buf_cnt != '0);
    assign out_if.out_data  = out_if.out_valid ? head_data : '0;
    assign pop              = out_if.out_valid & out_if.out_ready;

    skid_buf #(
        .DATA_BITS  (DATA_BITS),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pending),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head_data (head_data),
        .count     (buf_cnt)
    );

    // NOTE: every signal written here gets its default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        occ_next = occupancy;
        if (wr_acc && !rd_acc && occupancy != OCC_BITS'(FIFO_DEPTH)) begin
            occ_next = occupancy + OCC_BITS'(1);
        end else if (rd_acc && !wr_acc && occupancy != '0) begin
            occ_next = occupancy - OCC_BITS'(1);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!fifo_empty) state_next = FETCH;
            FETCH: begin
                if (!has_credit) begin
                    state_next = STALL;
                end else if (fifo_empty && !fifo_read) begin
                    state_next = IDLE;
                end
            end
            STALL:   if (has_credit) state_next = FETCH;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase
        if (err_now) begin
            state_next = ERR;
        end
        // Gating on the next state lets the first read leave IDLE without a dead cycle.
        read_next = (state_next == FETCH) & ~fifo_empty & avail & has_credit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fifo_read   <= 1'b0;
            rd_pending  <= 1'b0;
            occupancy   <= '0;
            pause_write <= 1'b0;
            error_out   <= 1'b0;
        end else begin
            state      <= state_next;
            fifo_read  <= read_next;
            rd_pending <= rd_acc;
            occupancy  <= occ_next;
            error_out  <= error_out | err_now;
            if (occupancy >= {1'b0, high_limit}) begin
                pause_write <= 1'b1;
            end else if (occupancy <= {1'b0, low_limit}) begin
                pause_write <= 1'b0;
            end
        end
    end

endmodule
